// File: rtl/count_pkg.sv
// Shared encodings for the count/status generator: FSM states and count direction.
package count_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic COUNT_UP = 1'b1;
  localparam logic COUNT_DN = 1'b0;

endpackage

// File: rtl/count_status_gen_counter.sv
// Bounded up/down counter: clamped load, inc/dec and wrap-reload strobes,
// plus terminal-value detection at both ends of [0, MAX_COUNT].
module updown_counter #(
  parameter int WIDTH     = 2,
  parameter int MAX_COUNT = (2**WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_set_zero,
  input  logic             i_set_max,
  output logic [WIDTH-1:0] o_count,
  output logic             o_at_max,
  output logic             o_at_zero
);

  localparam logic [WIDTH-1:0] MAX_C = MAX_COUNT[WIDTH-1:0];

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_load_clamped;

  assign w_load_clamped = (i_load_val > MAX_C) ? MAX_C : i_load_val;

  // inc/dec are only asserted by the caller when the bound has not been reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= w_load_clamped;
    end else if (i_set_zero) begin
      r_count <= '0;
    end else if (i_set_max) begin
      r_count <= MAX_C;
    end else if (i_inc && (r_count != MAX_C)) begin
      r_count <= r_count + WIDTH'(1);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count   = r_count;
  assign o_at_max  = (r_count == MAX_C);
  assign o_at_zero = (r_count == '0);

endmodule

// File: rtl/count_status_gen.sv
// Upstream count/status source for the status register: start/stop up/down
// counter whose terminal-count flag is held until acknowledged downstream.
module count_status_gen
  import count_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int MAX_COUNT = (2**WIDTH) - 1,
  parameter int WRAP      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_down,
  input  logic             status_ack,
  output logic [WIDTH-1:0] count,
  output logic             status,
  output logic             busy
);

  state_t r_state;
  logic   r_status;
  logic   r_busy;
  logic   r_term_max;

  logic   w_at_max;
  logic   w_at_zero;
  logic   w_terminal;
  logic   w_load;
  logic   w_run_cnt;
  logic   w_ack_wrap;

  assign w_terminal = (up_down == COUNT_UP) ? w_at_max : w_at_zero;
  assign w_load     = load && ((r_state == IDLE) || (r_state == RUN));
  assign w_run_cnt  = (r_state == RUN) && !load && !stop && !w_terminal;
  assign w_ack_wrap = (r_state == HOLD) && status_ack && (WRAP != 0);

  updown_counter #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (load_val),
    .i_inc      (w_run_cnt && (up_down == COUNT_UP)),
    .i_dec      (w_run_cnt && (up_down == COUNT_DN)),
    .i_set_zero (w_ack_wrap && r_term_max),
    .i_set_max  (w_ack_wrap && !r_term_max),
    .o_count    (count),
    .o_at_max   (w_at_max),
    .o_at_zero  (w_at_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_status   <= 1'b0;
      r_busy     <= 1'b0;
      r_term_max <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!load && start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (load) begin
            r_state <= RUN;
          end else if (stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_terminal) begin
            r_state    <= HOLD;
            r_status   <= 1'b1;
            r_term_max <= (up_down == COUNT_UP);
          end
        end
        HOLD: begin
          // load/start/stop are deliberately not looked at while waiting for ack
          if (status_ack) begin
            r_status <= 1'b0;
            if (WRAP != 0) begin
              r_state <= RUN;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_status <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign status = r_status;
  assign busy   = r_busy;

endmodule
